// File: rtl/right_shifter_seq_pkg.sv
// Shared types and default widths for the iterative right shifter.
package right_shifter_pkg;

  localparam int IN_WIDTH  = 16;
  localparam int OUT_WIDTH = 8;
  localparam int AMT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/right_shifter_seq_if.sv
// Request/result handshake bundle between a producer/consumer and the shifter.
interface right_shifter_seq_if #(
  parameter int IN_WIDTH  = right_shifter_pkg::IN_WIDTH,
  parameter int OUT_WIDTH = right_shifter_pkg::OUT_WIDTH,
  parameter int AMT_WIDTH = right_shifter_pkg::AMT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  shift_in;
  logic [AMT_WIDTH-1:0] shift_cntrl;
  logic                 arith;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] shift_out;
  logic                 overflow;
  logic                 sticky;

  modport master (
    output in_valid, shift_in, shift_cntrl, arith, out_ready,
    input  in_ready, out_valid, shift_out, overflow, sticky
  );

  modport slave (
    input  in_valid, shift_in, shift_cntrl, arith, out_ready,
    output in_ready, out_valid, shift_out, overflow, sticky
  );

endinterface

// File: rtl/right_shifter_seq.sv
// Iterative right shifter: one bit per clock, low OUT_WIDTH bits returned
// with overflow and sticky (discarded-bits) flags.
//
// state | meaning
// IDLE  | ready for a request; captures operand on in_valid
// SHIFT | shifting right one bit per cycle until cnt reaches 1
// DONE  | result held stable until out_ready
module right_shifter_seq
  import right_shifter_pkg::*;
#(
  parameter int IN_WIDTH  = right_shifter_pkg::IN_WIDTH,
  parameter int OUT_WIDTH = right_shifter_pkg::OUT_WIDTH,
  parameter int AMT_WIDTH = right_shifter_pkg::AMT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  right_shifter_seq_if.slave  bus
);

  state_e               state_q;
  state_e               state_d;
  logic [IN_WIDTH-1:0]  data_q;
  logic [AMT_WIDTH-1:0] cnt_q;
  logic                 mode_q;
  logic                 sticky_q;
  logic                 in_ready;
  logic                 out_valid;
  logic                 take;
  logic                 overflow;

  assign take = in_ready && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid)
          state_d = (bus.shift_cntrl == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_q == AMT_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else if (take) begin
      data_q   <= bus.shift_in;
      cnt_q    <= bus.shift_cntrl;
      mode_q   <= bus.arith;
      sticky_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      sticky_q <= sticky_q | data_q[0];
      data_q   <= {mode_q & data_q[IN_WIDTH-1], data_q[IN_WIDTH-1:1]};
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // Overflow is derived from the registered data, so it only moves while shifting.
  generate
    if (OUT_WIDTH < IN_WIDTH) begin : g_ovf
      logic [IN_WIDTH-OUT_WIDTH-1:0] upper;
      assign upper    = data_q[IN_WIDTH-1:OUT_WIDTH];
      assign overflow = mode_q ? (upper != {(IN_WIDTH-OUT_WIDTH){data_q[OUT_WIDTH-1]}})
                               : (|upper);
    end else begin : g_no_ovf
      assign overflow = 1'b0;
    end
  endgenerate

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.shift_out = data_q[OUT_WIDTH-1:0];
  assign bus.overflow  = overflow;
  assign bus.sticky    = sticky_q;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Directed bench for right_shifter_seq with hand-computed expected results.
module tb_right_shifter_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   lat;

  always #5 clk = ~clk;

  right_shifter_seq_if bus ();

  right_shifter_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, waits (bounded) for out_valid, checks latency and result.
  task automatic request(input string tag, input logic [15:0] d, input logic [3:0] a,
                         input logic ar, input logic [7:0] e_out, input logic e_ovf,
                         input logic e_sticky, output int cycles);
    bus.shift_in    = d;
    bus.shift_cntrl = a;
    bus.arith       = ar;
    bus.in_valid    = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    cycles = 0;
    do begin
      step();
      bus.in_valid = 1'b0;
      cycles++;
    end while (!bus.out_valid && cycles < 40);
    chk({tag, "_latency"}, 32'(cycles), 32'(a) + 32'd1);
    chk({tag, "_shift_out"}, 32'(bus.shift_out), 32'(e_out));
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'(e_ovf));
    chk({tag, "_sticky"}, 32'(bus.sticky), 32'(e_sticky));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.shift_in    = '0;
    bus.shift_cntrl = '0;
    bus.arith       = 1'b0;
    bus.out_ready   = 1'b0;

    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_shift_out", 32'(bus.shift_out), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_sticky", 32'(bus.sticky), 32'd0);
    step();
    rst = 1'b0;
    step();

    request("v0a00_8", 16'h0A00, 4'd8, 1'b0, 8'h0A, 1'b0, 1'b0, lat);
    handshake("v0a00_8");
    request("v00a5_0", 16'h00A5, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0, lat);
    handshake("v00a5_0");
    request("v1234_4", 16'h1234, 4'd4, 1'b0, 8'h23, 1'b1, 1'b1, lat);
    handshake("v1234_4");
    request("v8000_15a", 16'h8000, 4'd15, 1'b1, 8'hFF, 1'b0, 1'b0, lat);
    handshake("v8000_15a");
    request("v8000_15l", 16'h8000, 4'd15, 1'b0, 8'h01, 1'b0, 1'b0, lat);
    handshake("v8000_15l");
    // 0x7FFF >>> 4 = 0x07FF: bit 7 set but upper byte 0x07, and four ones dropped
    request("v7fff_4a", 16'h7FFF, 4'd4, 1'b1, 8'hFF, 1'b1, 1'b1, lat);
    handshake("v7fff_4a");
    // 0xF0F1 >>> 1 = 0xF878: negative, upper 0xF8 vs bit7=0 -> overflow
    request("vf0f1_1a", 16'hF0F1, 4'd1, 1'b1, 8'h78, 1'b1, 1'b1, lat);
    handshake("vf0f1_1a");

    // Hold in DONE with out_ready low while in_valid toggles.
    request("hold", 16'h1234, 4'd4, 1'b0, 8'h23, 1'b1, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid    = i[0];
      bus.shift_in    = 16'hFFFF;
      bus.shift_cntrl = 4'd0;
      bus.arith       = 1'b1;
      step();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_shift_out", 32'(bus.shift_out), 32'h23);
      chk("hold_overflow", 32'(bus.overflow), 32'd1);
      chk("hold_sticky", 32'(bus.sticky), 32'd1);
    end
    // in_valid high through the handshake must not be taken in that cycle.
    bus.in_valid = 1'b1;
    handshake("hold");
    bus.in_valid = 1'b0;
    bus.arith    = 1'b0;
    step();

    // Reset three cycles into a 10-bit shift.
    bus.shift_in    = 16'h1234;
    bus.shift_cntrl = 4'd10;
    bus.in_valid    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("mid_shifting", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_shift_out", 32'(bus.shift_out), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_sticky", 32'(bus.sticky), 32'd0);
    step();
    rst = 1'b0;
    step();
    request("vff00_8", 16'hFF00, 4'd8, 1'b0, 8'hFF, 1'b0, 1'b0, lat);
    handshake("vff00_8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
